// File: rtl/onchip_wave_ram_if.sv
// Avalon-MM bus carrying the Nios II side (Port A) of the waveform RAM.
interface onchip_wave_ram_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11
);
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic                    chipselect;
    logic                    clken;
    logic                    write;
    logic                    read;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;

    modport master (
        output address, byteenable, chipselect, clken, write, read, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, chipselect, clken, write, read, writedata,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_wave_ram.sv
// onchip_wave_ram: dual-port waveform table for the DDS datapath.
// Port A is an Avalon-MM slave with byte-lane writes and pipelined reads.
// Port B is addressed by an internal phase accumulator and streams one
// table sample per enabled clock. OUT_REG adds one register stage to both
// ports so their read latencies always match.
module onchip_wave_ram #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 11,
    parameter int OUT_REG     = 0,
    parameter int PHASE_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    onchip_wave_ram_if.slave       avs,
    input  logic                   dds_en,
    input  logic                   dds_sync,
    input  logic [PHASE_WIDTH-1:0] freq_word,
    input  logic [PHASE_WIDTH-1:0] phase_offset,
    output logic [DATA_WIDTH-1:0]  wave_data,
    output logic                   wave_valid
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [PHASE_WIDTH-1:0] acc;
    logic [PHASE_WIDTH-1:0] phase_sum;
    logic [ADDR_WIDTH-1:0]  wave_addr;
    logic                   a_wr;
    logic                   a_rd;

    // A simultaneous read+write is a write only, so reads require write low.
    assign a_wr = avs.chipselect & avs.clken & avs.write;
    assign a_rd = avs.chipselect & avs.clken & avs.read & ~avs.write;

    // A sync lookup uses a zero accumulator; the sum wraps modulo 2**PHASE_WIDTH.
    assign phase_sum = (dds_sync ? {PHASE_WIDTH{1'b0}} : acc) + phase_offset;
    assign wave_addr = ADDR_WIDTH'(phase_sum >> (PHASE_WIDTH - ADDR_WIDTH));

    // Port A byte-lane write; contents are deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (a_wr) begin
            for (int i = 0; i < LANES; i++) begin
                if (avs.byteenable[i]) begin
                    mem[avs.address][8*i +: 8] <= avs.writedata[8*i +: 8];
                end
            end
        end
    end

    // Phase accumulator: sync forces zero, otherwise advance only when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (dds_sync) begin
            acc <= '0;
        end else if (dds_en) begin
            acc <= acc + freq_word;
        end
    end

    if (OUT_REG == 0) begin : g_lat1
        // Array reads land directly in the holding output registers (latency 1).
        always_ff @(posedge clk) begin
            if (reset) begin
                avs.readdata      <= '0;
                avs.readdatavalid <= 1'b0;
                wave_data         <= '0;
                wave_valid        <= 1'b0;
            end else begin
                avs.readdatavalid <= a_rd;
                wave_valid        <= dds_en;
                if (a_rd) begin
                    avs.readdata <= mem[avs.address];
                end
                if (dds_en) begin
                    wave_data <= mem[wave_addr];
                end
            end
        end
    end else begin : g_lat2
        logic [DATA_WIDTH-1:0] a_q;
        logic [DATA_WIDTH-1:0] b_q;
        logic                  a_q_valid;
        logic                  b_q_valid;

        // Unconditional first-stage reads keep reset and enables off the RAM outputs.
        always_ff @(posedge clk) begin
            a_q <= mem[avs.address];
            b_q <= mem[wave_addr];
        end

        // First-stage valid bits; clearing them on reset kills reads in flight.
        always_ff @(posedge clk) begin
            if (reset) begin
                a_q_valid <= 1'b0;
                b_q_valid <= 1'b0;
            end else begin
                a_q_valid <= a_rd;
                b_q_valid <= dds_en;
            end
        end

        // Output stage loads only on a valid sample and holds otherwise (latency 2).
        always_ff @(posedge clk) begin
            if (reset) begin
                avs.readdata      <= '0;
                avs.readdatavalid <= 1'b0;
                wave_data         <= '0;
                wave_valid        <= 1'b0;
            end else begin
                avs.readdatavalid <= a_q_valid;
                wave_valid        <= b_q_valid;
                if (a_q_valid) begin
                    avs.readdata <= a_q;
                end
                if (b_q_valid) begin
                    wave_data <= b_q;
                end
            end
        end
    end
endmodule
